// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Fetch controller between the program counter and the decode stage. When
// enabled it reads the current pc, fetches one instruction word from
// instruction memory over a req/gnt/rvalid bus, and then holds that word for
// decode behind a valid/ready handshake. The PC is told to advance (pc_load)
// exactly once, in the cycle decode accepts the word.
//
// Parameters
//   XLEN     address/data width
//   TIMEOUT  maximum number of WAIT cycles for rvalid before a timeout fault
//            (must be >= 1)
//
// Ports
//   clk          in   rising-edge clock
//   a_rst        in   asynchronous reset, active-low
//   en           in   run enable, only looked at while idle
//   pc           in   current PC from the program counter
//   pc_load      out  1-cycle pulse: PC advances at this edge
//   imem_req     out  fetch request
//   imem_addr    out  fetch address (pc while imem_req, else 0)
//   imem_gnt     in   request accepted this cycle
//   imem_rvalid  in   read data valid
//   imem_rdata   in   read data
//   instr_valid  out  instr/instr_pc valid to decode
//   instr        out  fetched instruction
//   instr_pc     out  address the instruction was fetched from
//   instr_ready  in   decode accepts instr
//   fetch_fault  out  sticky fault flag (cleared only by reset)
//   fault_cause  out  01 misaligned pc, 10 rvalid timeout, 00 none
// -----------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            a_rst,
    input  logic            en,
    input  logic [XLEN-1:0] pc,
    output logic            pc_load,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            fetch_fault,
    output logic [1:0]      fault_cause
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Last counter value at which a silent WAIT cycle still counts as "in time";
    // a WAIT cycle seen with this value is the TIMEOUT-th one.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic [1:0]      cause_q;

    logic misaligned;
    logic timed_out;

    assign misaligned = (pc[1:0] != 2'b00);
    // rvalid in the final allowed cycle takes priority over the timeout.
    assign timed_out  = !imem_rvalid && (wait_cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (en) begin
                    state_nxt = misaligned ? S_FAULT : S_REQ;
                end
            end
            S_REQ: begin
                if (imem_gnt) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = S_HOLD;
                end else if (timed_out) begin
                    state_nxt = S_FAULT;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            cause_q    <= 2'b00;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (en && misaligned) begin
                        cause_q <= CAUSE_MISALIGN;
                    end
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        instr_pc_q <= pc;
                        wait_cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                    end else if (timed_out) begin
                        cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = (state == S_REQ);
    assign imem_addr   = imem_req ? pc : '0;
    assign instr_valid = (state == S_HOLD);
    // Combinational so the PC advances on the very edge decode takes the word.
    assign pc_load     = instr_valid && instr_ready;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_fault = (state == S_FAULT);
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            a_rst;
    logic            en;
    logic [XLEN-1:0] pc_in;
    logic            pc_load;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            fetch_fault;
    logic [1:0]      fault_cause;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [XLEN-1:0] word;
        logic [XLEN-1:0] addr;
    } exp_t;
    exp_t sb[$];

    instr_fetch_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .a_rst       (a_rst),
        .en          (en),
        .pc          (pc_in),
        .pc_load     (pc_load),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .fetch_fault (fetch_fault),
        .fault_cause (fault_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   imem_req,    0);
        chk({tag, "_addr"},  imem_addr,   0);
        chk({tag, "_load"},  pc_load,     0);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_instr"}, instr,       0);
        chk({tag, "_ipc"},   instr_pc,    0);
        chk({tag, "_fault"}, fetch_fault, 0);
        chk({tag, "_cause"}, fault_cause, 0);
    endtask

    // Asserts reset mid-cycle and checks that outputs clear without a clock edge.
    task automatic do_reset(input string tag);
        a_rst = 1'b0;
        #1;
        chk_all_zero(tag);
        step();
        step();
        a_rst = 1'b1;
    endtask

    // One complete fetch as the memory and decode would see it. Must be called
    // with the controller idle. gdly = cycles before grant, rdly = WAIT cycle
    // (1..TIMEOUT) that carries rvalid, rdy_dly = HOLD cycles before ready.
    task automatic fetch(input logic [XLEN-1:0] a, input int gdly, input int rdly,
                         input int rdy_dly, input logic [XLEN-1:0] data);
        pc_in = a;
        en    = 1'b1;
        step();
        chk("req_latency", imem_req, 1);
        // en dropping mid-fetch must not abort the fetch
        en = 1'($urandom_range(0, 1));
        for (int k = 0; k < gdly; k++) begin
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            chk("req_held", imem_req, 1);
            chk("addr_held", imem_addr, a);
            step();
        end
        imem_gnt = 1'b1;
        chk("addr_at_gnt", imem_addr, a);
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        chk("req_drop", imem_req, 0);
        chk("addr_drop", imem_addr, 0);
        for (int k = 1; k < rdly; k++) begin
            chk("wait_no_valid", instr_valid, 0);
            chk("wait_no_fault", fetch_fault, 0);
            step();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        sb.push_back('{word: data, addr: a});
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        chk("valid_after_rvalid", instr_valid, 1);
        instr_ready = 1'b0;
        for (int k = 0; k < rdy_dly; k++) begin
            step();
            chk("hold_valid", instr_valid, 1);
        end
        instr_ready = 1'b1;
        en = 1'b0;
        step();
        chk("valid_drop", instr_valid, 0);
        chk("pc_load_once", pc_load, 0);
        instr_ready = 1'b0;
    endtask

    // Scoreboard monitor: every accepted instruction must match the oldest
    // outstanding expectation; a held instruction must not change.
    initial begin : monitor
        logic            prev_hold;
        logic [XLEN-1:0] prev_instr;
        logic [XLEN-1:0] prev_ipc;
        exp_t            e;
        prev_hold  = 1'b0;
        prev_instr = '0;
        prev_ipc   = '0;
        forever begin
            @(negedge clk);
            if (a_rst === 1'b1) begin
                if (prev_hold && instr_valid) begin
                    chk("hold_instr_stable", instr, prev_instr);
                    chk("hold_pc_stable", instr_pc, prev_ipc);
                end
                if (instr_valid && instr_ready) begin
                    chk("pc_load_on_accept", pc_load, 1);
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_instr: got %0h at %0h, expected none", instr, instr_pc);
                    end else begin
                        e = sb.pop_front();
                        chk("instr", instr, e.word);
                        chk("instr_pc", instr_pc, e.addr);
                    end
                end else begin
                    chk("pc_load_idle", pc_load, 0);
                end
                prev_hold  = instr_valid && !instr_ready;
                prev_instr = instr;
                prev_ipc   = instr_pc;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        a_rst       = 1'b0;
        en          = 1'b0;
        pc_in       = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        #1;
        chk_all_zero("por");
        step();
        step();
        a_rst = 1'b1;
        step();

        // basic minimum-latency fetch
        fetch(32'h0, 0, 1, 0, 32'h0050_0093);
        // decode stalls five cycles
        fetch(32'h4, 0, 1, 5, $urandom);
        // grant delayed three cycles
        fetch(32'h10, 3, 1, 0, $urandom);

        for (int i = 0; i < 30; i++) begin
            fetch($urandom & 32'hFFFF_FFFC, $urandom_range(0, 4),
                  $urandom_range(1, TIMEOUT), $urandom_range(0, 4), $urandom);
        end

        // rvalid never arrives: fault after exactly TIMEOUT WAIT cycles
        pc_in = 32'h20;
        en    = 1'b1;
        step();
        en       = 1'b0;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) begin
            chk("to_no_fault_yet", fetch_fault, 0);
            chk("to_req_low", imem_req, 0);
            step();
        end
        chk("to_last_cycle", fetch_fault, 0);
        step();
        chk("to_fault", fetch_fault, 1);
        chk("to_cause", fault_cause, 2'b10);
        // fault is sticky and ignores the bus and en
        en          = 1'b1;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("to_sticky", fetch_fault, 1);
            chk("to_sticky_req", imem_req, 0);
            chk("to_sticky_valid", instr_valid, 0);
        end
        en          = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        do_reset("rst_after_to");
        step();

        // rvalid in the final allowed WAIT cycle wins over the timeout
        fetch(32'h24, 0, TIMEOUT, 1, $urandom);

        // misaligned pc
        pc_in = 32'h0000_0006;
        en    = 1'b1;
        step();
        chk("mis_fault", fetch_fault, 1);
        chk("mis_cause", fault_cause, 2'b01);
        for (int k = 0; k < 3; k++) begin
            chk("mis_no_req", imem_req, 0);
            step();
        end
        en = 1'b0;
        do_reset("rst_after_mis");
        step();

        // reset during WAIT, then stray rvalid, then a fresh fetch
        pc_in = 32'h40;
        en    = 1'b1;
        step();
        en       = 1'b0;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        step();
        do_reset("rst_in_wait");
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stray_no_valid", instr_valid, 0);
            chk("stray_instr", instr, 0);
        end
        imem_rvalid = 1'b0;
        fetch(32'h40, 1, 2, 0, 32'h1234_5678);

        step();
        step();
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
